// File: rtl/aes_pkg.sv
// Shared AES constants, state encoding and word helpers used by the key schedules.
package aes_pkg;

    localparam int NR     = 10;
    localparam int NK     = 4;
    localparam int KEY_W  = 128;
    localparam int WORD_W = 32;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Round constant for the given round number (1..10); zero outside that range.
    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Rotate a word left by one byte.
    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // XOR chain of the backward step: word 0 is passed through untouched,
    // every other word is XORed with its left neighbour.
    function automatic logic [KEY_W-1:0] step_tail(input logic [KEY_W-1:0] k);
        logic [WORD_W-1:0] a, b, c, d;
        a = k[127:96];
        b = k[95:64];
        c = k[63:32];
        d = k[31:0];
        return {a, b ^ a, c ^ b, d ^ c};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Multiply two field elements modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // Inverse as x^254 = x^2 * x^4 * ... * x^128; zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] inv;

    // Inverse then affine transform with constant 0x63.
    always_comb begin
        inv    = gf_inv(i_byte);
        o_byte = inv
               ^ {inv[6:0], inv[7]}
               ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]}
               ^ 8'h63;
    end

endmodule

// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule: replays round keys 10 down to 0 from the last round key, one per accepted beat.
module inv_key_schedule
    import aes_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [KEY_W-1:0] i_last_round_key,
    input  logic             i_ready,
    output logic [KEY_W-1:0] o_round_key,
    output logic [3:0]       o_round_idx,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_done
);

    state_t             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [KEY_W-1:0]   tail;
    logic [WORD_W-1:0]  rot_d;
    logic [WORD_W-1:0]  sub_rot;
    logic [KEY_W-1:0]   prev_key;

    assign tail  = step_tail(key_q);
    assign rot_d = rot_word(tail[31:0]);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (rot_d[8*g +: 8]),
            .o_byte (sub_rot[8*g +: 8])
        );
    end

    // Previous round key: word 0 absorbs SubWord(RotWord(new word 3)) and the current round's Rcon.
    always_comb begin
        prev_key = {tail[127:96] ^ sub_rot ^ {rcon(idx_q), 24'h000000}, tail[95:0]};
    end

    // Next-state logic: load on start, step backwards on each accepted beat, finish after round 0.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        key_d   = key_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = RUN;
                    key_d   = i_last_round_key;
                    idx_d   = 4'(NR);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (valid_q && i_ready) begin
                    if (idx_q == 4'd0) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        key_d = prev_key;
                        idx_d = idx_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset that clears everything and drops any run in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            key_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_round_key = key_q;
    assign o_round_idx = idx_q;
    assign o_valid     = valid_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Randomized scoreboard bench for inv_key_schedule with a word-array AES key expansion run in reverse.
module tb_inv_key_schedule;

    logic         i_clk;
    logic         i_rst;
    logic         i_start;
    logic [127:0] i_last_round_key;
    logic         i_ready;
    logic [127:0] o_round_key;
    logic [3:0]   o_round_idx;
    logic         o_valid;
    logic         o_busy;
    logic         o_done;

    typedef struct {
        logic [127:0] key;
        logic [3:0]   idx;
    } beat_t;

    beat_t        sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [7:0]   sbox_tab[0:255];
    logic [7:0]   rc_tab[1:10];
    logic [127:0] model_rk[0:10];

    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    inv_key_schedule dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_start          (i_start),
        .i_last_round_key (i_last_round_key),
        .i_ready          (i_ready),
        .o_round_key      (o_round_key),
        .o_round_idx      (o_round_idx),
        .o_valid          (o_valid),
        .o_busy           (o_busy),
        .o_done           (o_done)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // S-box built from the generator-3 log walk, Rcon from repeated doubling.
    function automatic void buildTables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_tab[p] = x ^ 8'h63;
        end
        sbox_tab[0] = 8'h63;
        rc_tab[1] = 8'h01;
        for (int i = 2; i <= 10; i++) begin
            rc_tab[i] = {rc_tab[i-1][6:0], 1'b0} ^ (rc_tab[i-1][7] ? 8'h1b : 8'h00);
        end
    endfunction

    // Reverse of w[i] = w[i-4] ^ temp over the 44-word schedule, then regroup into round keys.
    function automatic void modelRun(input logic [127:0] last_key);
        logic [31:0] w[0:43];
        logic [31:0] t;
        for (int j = 0; j < 4; j++) w[40 + j] = last_key[127 - 32*j -: 32];
        for (int i = 43; i >= 4; i--) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t = t ^ {rc_tab[i/4], 24'h000000};
            end
            w[i-4] = w[i] ^ t;
        end
        for (int r = 0; r <= 10; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Start a run from idle and queue the 11 beats it must produce.
    task automatic applyStimulus(input logic [127:0] key, input bit fips, input bit zero_key);
        modelRun(key);
        if (fips) begin
            model_rk[9] = FIPS_K9;
            model_rk[1] = FIPS_K1;
            model_rk[0] = FIPS_K0;
        end
        if (zero_key) model_rk[0] = '0;
        for (int r = 10; r >= 0; r--) sb.push_back('{key: model_rk[r], idx: 4'(r)});
        i_start          = 1'b1;
        i_last_round_key = key;
        tick();
        i_start          = 1'b0;
        i_last_round_key = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Drive i_ready until the run drains, with optional stall, ignored start or reset at given indices.
    task automatic drainRun(input bit rand_ready, input int stall_idx, input int busy_idx, input int rst_idx);
        bit stalled  = 1'b0;
        bit poked    = 1'b0;
        bit finished = 1'b0;
        int stall_left = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            i_start = 1'b0;
            if (sb.size() == 0 && !o_valid) begin
                finished = 1'b1;
                break;
            end
            if (rst_idx >= 0 && o_valid && o_round_idx == 4'(rst_idx)) begin
                i_rst = 1'b1;
                tick();
                checkOutput("rst_valid", o_valid, 0);
                checkOutput("rst_busy", o_busy, 0);
                checkOutput("rst_done", o_done, 0);
                checkOutput("rst_key", o_round_key, 0);
                checkOutput("rst_idx", o_round_idx, 0);
                i_rst = 1'b0;
                sb.delete();
                finished = 1'b1;
                break;
            end
            if (stall_left > 0) begin
                i_ready = 1'b0;
                stall_left--;
            end else if (stall_idx >= 0 && !stalled && o_valid && o_round_idx == 4'(stall_idx)) begin
                stalled    = 1'b1;
                stall_left = 4;
                i_ready    = 1'b0;
            end else begin
                i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (busy_idx >= 0 && !poked && o_valid && o_round_idx == 4'(busy_idx)) begin
                poked            = 1'b1;
                i_start          = 1'b1;
                i_last_round_key = {$urandom, $urandom, $urandom, $urandom};
            end
            tick();
        end
        i_start = 1'b0;
        if (!finished) checkOutput("drain_timeout", 0, 1);
    endtask

    // Monitor: pops the scoreboard on every transfer, checks stall stability and the done pulse.
    initial begin
        bit           exp_done = 1'b0;
        bit           prev_stall = 1'b0;
        logic [127:0] prev_key = '0;
        logic [3:0]   prev_idx = '0;
        beat_t        e;
        forever begin
            @(negedge i_clk);
            checkOutput("done_pulse", o_done, exp_done);
            if (prev_stall) begin
                checkOutput("stall_valid", o_valid, 1);
                checkOutput("stall_key", o_round_key, prev_key);
                checkOutput("stall_idx", o_round_idx, prev_idx);
            end
            exp_done = 1'b0;
            if (o_valid && i_ready && !i_rst) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_beat", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("round_key", o_round_key, e.key);
                    checkOutput("round_idx", o_round_idx, e.idx);
                    if (e.idx == 4'd0) exp_done = 1'b1;
                end
            end
            prev_stall = o_valid && !i_ready && !i_rst;
            prev_key   = o_round_key;
            prev_idx   = o_round_idx;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence of directed scenarios followed by random keys under random backpressure.
    initial begin
        buildTables();
        i_rst            = 1'b1;
        i_start          = 1'b1;
        i_ready          = 1'b1;
        i_last_round_key = FIPS_K10;
        tick();
        tick();
        tick();
        checkOutput("reset_valid", o_valid, 0);
        checkOutput("reset_busy", o_busy, 0);
        checkOutput("reset_done", o_done, 0);
        checkOutput("reset_key", o_round_key, 0);
        checkOutput("reset_idx", o_round_idx, 0);
        i_rst   = 1'b0;
        i_start = 1'b0;
        tick();

        $display("[TB] FIPS-197 run");
        i_ready = 1'b1;
        applyStimulus(FIPS_K10, 1'b1, 1'b0);
        checkOutput("first_valid", o_valid, 1);
        checkOutput("first_idx", o_round_idx, 10);
        checkOutput("first_key", o_round_key, FIPS_K10);
        checkOutput("first_busy", o_busy, 1);
        drainRun(1'b0, -1, -1, -1);
        checkOutput("done_after_round0", o_done, 1);
        checkOutput("busy_after_round0", o_busy, 0);

        $display("[TB] back-to-back start with zero cipher key");
        applyStimulus(ZERO_K10, 1'b0, 1'b1);
        drainRun(1'b0, -1, -1, -1);

        $display("[TB] backpressure");
        applyStimulus(FIPS_K10, 1'b1, 1'b0);
        drainRun(1'b1, 6, -1, -1);

        $display("[TB] start while busy");
        applyStimulus(FIPS_K10, 1'b1, 1'b0);
        drainRun(1'b1, -1, 4, -1);

        $display("[TB] reset mid-run");
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        drainRun(1'b1, -1, -1, 3);
        tick();
        applyStimulus(FIPS_K10, 1'b1, 1'b0);
        drainRun(1'b0, -1, -1, -1);

        $display("[TB] random keys");
        for (int n = 0; n < 6; n++) begin
            applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
            drainRun(1'b1, -1, -1, -1);
        end

        tick();
        tick();
        checkOutput("final_queue_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
